pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the combinational 32-bit adder in the MIPS datapath.
- Computes add or subtract with carry/borrow-in over WIDTH bits.
- Splits the carry chain into STAGES registered segments to close timing at higher clock rates.
- Uses a valid/ready handshake with backpressure; produces carry-out, signed overflow, zero and negative flags for the ALU/branch logic.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 2.
- STAGES, 4: number of pipeline segments; each segment computes WIDTH/STAGES bits. WIDTH % STAGES must equal 0 and STAGES must be at least 1; an elaboration-time error is raised otherwise.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present this cycle.
- in_ready  out  1  block can accept operands this cycle.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B.
- carryin  in  1  add: carry-in; sub: borrow-in.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- output1  out  WIDTH  result.
- carryout  out  1  add: carry-out; sub: 1 = no borrow.
- overflow  out  1  two's-complement overflow.
- zero  out  1  output1 == 0.
- negative  out  1  output1[WIDTH-1].

Behaviour:
- Reset (synchronous, active-high, on a clk edge with reset=1):
  - All stage valid bits, out_valid, output1, carryout, overflow, zero and negative clear to 0.
  - Any in-flight transaction is dropped, including mid-pipeline; there is no partial result.
  - in_ready is 0 while reset=1 and 1 in the first cycle after reset deasserts.
- Operand transform at accept time:
  - Effective B = sub ? ~input2 : input2.
  - Effective carry-in = sub ? ~carryin : carryin.
  - So sub=1 yields input1 - input2 - carryin.
- Segmentation:
  - Segment i covers bits [(i+1)*W/S-1 : i*W/S].
  - Stage i adds its slice plus the carry registered from stage i-1, and registers the partial sum, carry, and the not-yet-consumed upper operand slices.
  - The final stage also registers the flags.
- Flags, computed from the full result:
  - carryout = carry out of bit WIDTH-1.
  - overflow = (A[MSB] == Beff[MSB]) && (result[MSB] != A[MSB]).
  - zero = ~|result.
  - negative = result[MSB].
- Handshake and stall:
  - advance = !out_valid || out_ready. The whole pipeline shifts one stage when advance=1; otherwise every stage holds.
  - in_ready = advance and not reset. A transfer occurs on an edge where in_valid && in_ready.
  - in_valid=0 on an advancing edge inserts a bubble (stage valid=0). Bubbles are not collapsed.
  - The output holds output1 and all flags stable while out_valid && !out_ready. Values must not change during a stall.
- Latency and throughput:
  - A transaction accepted at edge k appears with out_valid=1 after edge k+STAGES-1 if there is no stall. For example, STAGES=1 gives the result in the cycle after accept; STAGES=4 gives it after the 4th edge counting the accept edge.
  - Throughput is one result per cycle when out_ready is held at 1.
  - Each stall cycle adds exactly one cycle to every in-flight transaction.
- Simultaneous events:
  - Output consumed and new input accepted on the same edge: both occur.
  - reset=1 overrides in_valid and out_ready.
- Wrap-around: the result is modulo 2^WIDTH; the discarded bit is reported only via carryout.
- No X propagation from input1/input2 when in_valid=0: stage payload registers may load, but out_valid gating defines validity.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Add with carryin: 1+3 with carryin=0, then 1+3 with carryin=1, on consecutive cycles with out_ready=1 -> 4 then 5 on consecutive out_valid cycles. The first appears 4 edges after accept. All flags 0.
- Overflow and wrap: 0x7FFFFFFF+1 -> 0x80000000, overflow=1, negative=1, carryout=0. Then 0xFFFFFFFF+1 -> 0x00000000, carryout=1, zero=1, overflow=0.
- Subtract: sub=1, 5-7 with carryin=0 -> 0xFFFFFFFE, carryout=0, negative=1. Then 7-5 with carryin=1 -> 1, carryout=1. Then 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
- Backpressure: stream 10,20,30,40 (+1 each), drop out_ready for 3 cycles once the first result is valid:
  - output1=11 held stable and in_ready=0 for 3 cycles.
  - Then 21,31,41 emerge in order with no loss or duplication.
- Reset mid-operation: accept 2 transactions, assert reset for 1 cycle while they are in flight -> out_valid stays 0. The next transaction, 2+2, produces exactly one result, 4, with latency 4.
- Parametrisation: WIDTH=8, STAGES=1 with 0xFF+0x01 -> 0x00, carryout=1, zero=1, one cycle after accept. WIDTH=64, STAGES=8 gives latency 8 and correct cross-segment carry on 0x00000000FFFFFFFF+1 = 0x0000000100000000.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - segmented add/subtract pipeline with valid/ready handshake and ALU flags
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             carryin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output1,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW   = (STAGES > 0) ? WIDTH / STAGES : WIDTH;
    localparam int LAST = STAGES - 1;

    generate
        if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of STAGES >= 1");
        end
    endgenerate

    // Each stage carries the full effective operands so every later slice is still available.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic             c_i [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic [SW:0]      slice;

    logic ov_q, z_q, n_q;
    logic ov_d, z_d, n_d;
    logic advance;

    assign advance  = !v_q[LAST] || out_ready;
    assign in_ready = advance && !reset;

    always_comb begin
        slice  = '0;
        a_i[0] = input1;
        b_i[0] = sub ? ~input2 : input2;
        c_i[0] = sub ^ carryin;
        s_i[0] = '0;
        for (int i = 1; i < STAGES; i++) begin
            a_i[i] = a_q[i-1];
            b_i[i] = b_q[i-1];
            c_i[i] = c_q[i-1];
            s_i[i] = s_q[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            slice = {1'b0, a_i[i][i*SW +: SW]} + {1'b0, b_i[i][i*SW +: SW]}
                  + {{SW{1'b0}}, c_i[i]};
            s_d[i] = s_i[i];
            s_d[i][i*SW +: SW] = slice[SW-1:0];
            c_d[i] = slice[SW];
        end
    end

    // Flags come from the complete sum produced in the final stage.
    always_comb begin
        ov_d = (a_i[LAST][WIDTH-1] == b_i[LAST][WIDTH-1])
            && (s_d[LAST][WIDTH-1] != a_i[LAST][WIDTH-1]);
        z_d  = ~|s_d[LAST];
        n_d  = s_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= 1'b0;
                v_q[i] <= 1'b0;
            end
            ov_q <= 1'b0;
            z_q  <= 1'b0;
            n_q  <= 1'b0;
        end else if (advance) begin
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= a_i[i];
                b_q[i] <= b_i[i];
                s_q[i] <= s_d[i];
                c_q[i] <= c_d[i];
            end
            v_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1];
            end
            ov_q <= ov_d;
            z_q  <= z_d;
            n_q  <= n_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign output1   = s_q[LAST];
    assign carryout  = c_q[LAST];
    assign overflow  = ov_q;
    assign zero      = z_q;
    assign negative  = n_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - randomized and directed bench for pipelined_add_sub
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [31:0] y;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] input1 = '0;
    logic [31:0] input2 = '0;
    logic        carryin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] output1;
    logic        carryout, overflow, zero, negative;

    logic        v8 = 1'b0, r8, ov8_valid, co8, ov8, z8, n8;
    logic [7:0]  a8 = '0, b8 = '0, y8;
    logic        v64 = 1'b0, r64, ov64_valid, co64, ovf64, z64, n64;
    logic [63:0] a64 = '0, b64 = '0, y64;
    logic        ready_p = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    res_t exp_q[$];
    int   exp_t[$];
    res_t got_q[$];
    int   got_t[$];

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2), .carryin(carryin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .output1(output1),
        .carryout(carryout), .overflow(overflow), .zero(zero), .negative(negative)
    );

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8),
        .input1(a8), .input2(b8), .carryin(1'b0), .sub(1'b0),
        .out_valid(ov8_valid), .out_ready(ready_p), .output1(y8),
        .carryout(co8), .overflow(ov8), .zero(z8), .negative(n8)
    );

    pipelined_add_sub #(.WIDTH(64), .STAGES(8)) dut64 (
        .clk(clk), .reset(reset), .in_valid(v64), .in_ready(r64),
        .input1(a64), .input2(b64), .carryin(1'b0), .sub(1'b0),
        .out_valid(ov64_valid), .out_ready(ready_p), .output1(y64),
        .carryout(co64), .overflow(ovf64), .zero(z64), .negative(n64)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: true integer add/subtract, flags derived from value ranges.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        res_t   m;
        longint ua, ub, r, sa, sb, sr;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!s) begin
            r    = ua + ub + longint'(c);
            sr   = sa + sb + longint'(c);
            m.co = (r >= 64'sh1_0000_0000);
        end else begin
            r    = ua - ub - longint'(c);
            sr   = sa - sb - longint'(c);
            m.co = (ua >= ub + longint'(c));
        end
        m.y  = r[31:0];
        m.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        m.z  = (m.y == 32'd0);
        m.n  = m.y[31];
        return m;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(input1, input2, carryin, sub));
                exp_t.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                got_q.push_back({output1, carryout, overflow, zero, negative});
                got_t.push_back(cyc);
            end
        end
    end

    task automatic clear_queues();
        exp_q.delete(); exp_t.delete(); got_q.delete(); got_t.delete();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        input1 = a; input2 = b; carryin = c; sub = s; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: in_ready never 1, required 1");
    endtask

    task automatic wait_results(input int n);
        for (int k = 0; k < 500; k++) begin
            if (got_q.size() >= n) return;
            @(posedge clk); #1;
        end
        n_cmp++; n_bad++;
        $display("FAIL result_timeout: got %0d results, required %0d", got_q.size(), n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, output1, carryout, overflow, zero, negative} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b y=%h flags=%b%b%b%b, required all 0",
                     in_ready, out_valid, output1, carryout, overflow, zero, negative);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_carry();
        clear_queues();
        send(32'd1, 32'd3, 1'b0, 1'b0);
        send(32'd1, 32'd3, 1'b1, 1'b0);
        wait_results(2);
        if (got_q.size() >= 2 && exp_q.size() >= 2) begin
            n_cmp++;
            if (got_q[0] !== {32'd4, 4'b0000} || got_q[1] !== {32'd5, 4'b0000}) begin
                n_bad++;
                $display("FAIL add_carry: got %h,%h required %h,%h",
                         got_q[0], got_q[1], {32'd4, 4'b0000}, {32'd5, 4'b0000});
            end
            n_cmp++;
            if (got_t[0] - exp_t[0] != 4 || got_t[1] != got_t[0] + 1) begin
                n_bad++;
                $display("FAIL add_latency: latency %0d gap %0d, required 4 and 1",
                         got_t[0] - exp_t[0], got_t[1] - got_t[0]);
            end
        end
    endtask

    task automatic test_flags();
        logic [31:0] av [5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000};
        logic [31:0] bv [5] = '{32'd1, 32'd1, 32'd7, 32'd5, 32'd1};
        logic        cv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        sv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        res_t        kv [5] = '{{32'h80000000, 4'b0101}, {32'h00000000, 4'b1010},
                                {32'hFFFFFFFE, 4'b0001}, {32'h00000001, 4'b1000},
                                {32'h7FFFFFFF, 4'b1100}};
        clear_queues();
        for (int i = 0; i < 5; i++) send(av[i], bv[i], cv[i], sv[i]);
        wait_results(5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== kv[i] || got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL flags_case%0d: got %h, required %h (model %h)",
                         i, got_q[i], kv[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int seen;
        clear_queues();
        fork
            begin
                for (int i = 1; i <= 4; i++) send(32'(i * 10), 32'd1, 1'b0, 1'b0);
            end
            begin
                seen = 0;
                for (int k = 0; k < 20 && !out_valid; k++) begin
                    @(posedge clk); #2;
                end
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #2;
                    n_cmp++;
                    if (output1 !== 32'd11 || out_valid !== 1'b1 || in_ready !== 1'b0
                        || {carryout, overflow, zero, negative} !== 4'b0000) begin
                        n_bad++;
                        $display("FAIL stall_hold%0d: y=%0d valid=%b in_ready=%b, required 11 1 0",
                                 k, output1, out_valid, in_ready);
                    end
                end
                out_ready = 1'b1;
            end
        join
        wait_results(4);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != 4) begin
            n_bad++;
            $display("FAIL bp_count: got %0d results, required 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_q[i].y !== 32'((i + 1) * 10 + 1)) begin
                    n_bad++;
                    $display("FAIL bp_order%0d: got %0d, required %0d", i, got_q[i].y, (i + 1) * 10 + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        send(32'd100, 32'd1, 1'b0, 1'b0);
        send(32'd200, 32'd1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_queues();
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_flush%0d: out_valid=%b, required 0", k, out_valid);
            end
            @(posedge clk); #1;
        end
        send(32'd2, 32'd2, 1'b0, 1'b0);
        wait_results(1);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != 1 || exp_t.size() != 1) begin
            n_bad++;
            $display("FAIL reset_count: got %0d results, required 1", got_q.size());
        end else if (got_q[0].y !== 32'd4 || got_t[0] - exp_t[0] != 4) begin
            n_bad++;
            $display("FAIL reset_result: y=%0d latency=%0d, required 4 and 4",
                     got_q[0].y, got_t[0] - exp_t[0]);
        end
    endtask

    task automatic test_random();
        bit done = 0;
        clear_queues();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a, b;
                    a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                    b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_results(40);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rand_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rand%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_param8();
        a8 = 8'hFF; b8 = 8'h01; v8 = 1'b1;
        #1;
        n_cmp++;
        if (r8 !== 1'b1) begin
            n_bad++;
            $display("FAIL p8_ready: in_ready=%b, required 1", r8);
        end
        @(posedge clk); #1;
        v8 = 1'b0;
        n_cmp++;
        if ({ov8_valid, y8, co8, ov8, z8, n8} !== {1'b1, 8'h00, 4'b1010}) begin
            n_bad++;
            $display("FAIL p8_result: valid=%b y=%h flags=%b%b%b%b, required 1 00 1010",
                     ov8_valid, y8, co8, ov8, z8, n8);
        end
    endtask

    task automatic test_param64();
        int edges;
        a64 = 64'h00000000FFFFFFFF; b64 = 64'd1; v64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        edges = 1;
        while (!ov64_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        n_cmp++;
        if (edges != 8) begin
            n_bad++;
            $display("FAIL p64_latency: %0d edges, required 8", edges);
        end
        n_cmp++;
        if (y64 !== 64'h0000000100000000 || co64 !== 1'b0 || z64 !== 1'b0) begin
            n_bad++;
            $display("FAIL p64_result: y=%h co=%b z=%b, required 0000000100000000 0 0", y64, co64, z64);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_flags();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_param8();
        test_param64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
